period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 13 +
 rtl/period_meter_ch.sv | 91 +++++++++
 rtl/period_meter.sv | 112 +++++++++++
 tb/tb_period_meter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared defaults and types for the multi-channel pulse period meter.
package period_meter_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int CNT_W_MAX  = 32;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] cnt;
    logic                 sat;
  } result_t;

endpackage

// File: rtl/period_meter_ch.sv
// One period-meter channel: edge detect, first-edge filter, saturating counter,
// 1-deep holding register and sticky overrun flag. PERIOD_METER_SYNC_EN adds a 2-flop input synchroniser.
module period_meter_ch
  import period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             pulse_i,
  input  logic             take_i,
  output logic             full_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o,
  output logic             ovr_o
);

  logic             sample;
  logic             prev_q;
  logic             armed_q, armed_d;
  logic             full_q, full_d;
  logic             hsat_q, hsat_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             edge_det, at_max, new_res;
  logic [CNT_W-1:0] cnt_inc;

`ifdef PERIOD_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) sync_q <= '0;
    else                sync_q <= {sync_q[0], pulse_i};
  end

  assign sample = sync_q[1];
`else
  assign sample = pulse_i;
`endif

  assign edge_det = sample & ~prev_q;
  assign at_max   = &cnt_q;
  assign cnt_inc  = at_max ? cnt_q : cnt_q + CNT_W'(1);
  assign new_res  = edge_det & armed_q;

  // The captured value is the count including the edge cycle itself.
  always_comb begin
    cnt_d   = edge_det ? '0 : cnt_inc;
    armed_d = armed_q | edge_det;
    full_d  = full_q;
    hcnt_d  = hcnt_q;
    hsat_d  = hsat_q;
    ovr_d   = ovr_q;
    if (new_res) begin
      full_d = 1'b1;
      hcnt_d = cnt_inc;
      hsat_d = at_max;
      if (full_q && !take_i) ovr_d = 1'b1;
    end else if (take_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      hcnt_q  <= '0;
      hsat_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= sample;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      hcnt_q  <= hcnt_d;
      hsat_q  <= hsat_d;
      ovr_q   <= ovr_d;
    end
  end

  assign full_o = full_q;
  assign cnt_o  = hcnt_q;
  assign sat_o  = hsat_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/period_meter.sv
// Multi-channel pulse period meter: NUM_CH channels, round-robin arbiter, registered
// valid/ready output. Define PERIOD_METER_SYNC_EN to synchronise the pulse inputs.
module period_meter
  import period_meter_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] pulse,
  output logic              o_vld,
  input  logic              o_rdy,
  output logic [CH_W-1:0]   o_ch,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_sat,
  output logic [NUM_CH-1:0] o_ovr
);

  logic [NUM_CH-1:0] ch_full, ch_sat, ch_ovr, req, take;
  logic [CNT_W-1:0]  ch_cnt [NUM_CH];

  logic              o_vld_q, o_vld_d;
  logic [CH_W-1:0]   o_ch_q, o_ch_d;
  logic [CNT_W-1:0]  o_cnt_q, o_cnt_d;
  logic              o_sat_q, o_sat_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;

  logic              flush, accept, gnt_found;
  logic [CH_W-1:0]   gnt_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    period_meter_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (en[i]),
      .pulse_i (pulse[i]),
      .take_i  (take[i]),
      .full_o  (ch_full[i]),
      .cnt_o   (ch_cnt[i]),
      .sat_o   (ch_sat[i]),
      .ovr_o   (ch_ovr[i])
    );
  end

  assign req = ch_full & en;

  // A result whose channel has just been disabled is withdrawn rather than delivered.
  assign flush  = o_vld_q && !en[o_ch_q];
  assign accept = !flush && (!o_vld_q || o_rdy);

  // ptr_q is the first channel searched, i.e. the one after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_found && req[(int'(ptr_q) + k) % NUM_CH]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'((int'(ptr_q) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    take = '0;
    if (accept && gnt_found) take[gnt_idx] = 1'b1;
  end

  always_comb begin
    o_vld_d = o_vld_q;
    o_ch_d  = o_ch_q;
    o_cnt_d = o_cnt_q;
    o_sat_d = o_sat_q;
    ptr_d   = ptr_q;
    if (flush) begin
      o_vld_d = 1'b0;
    end else if (accept) begin
      o_vld_d = gnt_found;
      if (gnt_found) begin
        o_ch_d  = gnt_idx;
        o_cnt_d = ch_cnt[gnt_idx];
        o_sat_d = ch_sat[gnt_idx];
        ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld_q <= 1'b0;
      o_ch_q  <= '0;
      o_cnt_q <= '0;
      o_sat_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      o_vld_q <= o_vld_d;
      o_ch_q  <= o_ch_d;
      o_cnt_q <= o_cnt_d;
      o_sat_q <= o_sat_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_vld = o_vld_q;
  assign o_ch  = o_ch_q;
  assign o_cnt = o_cnt_q;
  assign o_sat = o_sat_q;
  assign o_ovr = ch_ovr;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (4 channels, 4-bit count); expected results are
// queued at stimulus time and checked by an independent output monitor.
module tb_period_meter;

  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic [3:0] pulse;
  logic       o_vld;
  logic       o_rdy;
  logic [1:0] o_ch;
  logic [3:0] o_cnt;
  logic       o_sat;
  logic [3:0] o_ovr;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] cnt;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  period_meter #(.NUM_CH(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pulse (pulse),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_ch  (o_ch),
    .o_cnt (o_cnt),
    .o_sat (o_sat),
    .o_ovr (o_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && o_vld && o_rdy) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got ch=%0d cnt=%0d sat=%0d, required no result",
                 o_ch, o_cnt, o_sat);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_ch, o_cnt, o_sat} !== mon_e) begin
          n_fail++;
          $display("FAIL result: got ch=%0d cnt=%0d sat=%0d, required ch=%0d cnt=%0d sat=%0d",
                   o_ch, o_cnt, o_sat, mon_e.ch, mon_e.cnt, mon_e.sat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input logic [3:0] p);
    pulse = p;
    @(posedge clk);
    #1;
    pulse = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'h0);
  endtask

  task automatic push(input int ch, input int cnt, input int sat);
    exp_t e;
    e.ch  = 2'(ch);
    e.cnt = 4'(cnt);
    e.sat = 1'(sat);
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {o_vld, o_ch, o_cnt, o_sat, o_ovr}, '0);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 4'h0;
    pulse = 4'h0;
    o_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset_outputs");
    en = 4'hF;
    idle(2);

    // ch0 period 10: first edge discarded, then three results of 10
    tick(4'h1); idle(9);
    for (int k = 0; k < 3; k++) begin
      push(0, 10, 0);
      tick(4'h1); idle(9);
    end
    idle(5);

    // ch1 periods 20, 15, 16 with a 4-bit counter
    tick(4'h2); idle(19);
    push(1, 15, 1); tick(4'h2); idle(14);
    push(1, 15, 0); tick(4'h2); idle(15);
    push(1, 15, 1); tick(4'h2); idle(20);

    // reset clears the stale output register and the arbiter pointer
    rst = 1'b1; tick(4'h0); rst = 1'b0;
    chk_zero("reset_mid_idle");

    // simultaneous edges: order 0..3, then ordered from the pointer
    tick(4'hF); idle(7);
    push(0, 8, 0); push(1, 8, 0); push(2, 8, 0); push(3, 8, 0);
    tick(4'hF); idle(7);
    push(1, 8, 0);
    tick(4'h2); idle(5);
    push(2, 14, 0); push(3, 14, 0); push(0, 14, 0); push(1, 6, 0);
    tick(4'hF); idle(20);

    // ch2 with downstream stalled for 12 cycles: overrun and stable output
    o_rdy = 1'b0;
    push(2, 15, 1);
    tick(4'h4); idle(4);
    chk("stall_hold_a", {o_vld, o_ch, o_cnt, o_sat}, {1'b1, 2'd2, 4'd15, 1'b1});
    tick(4'h4); idle(5);
    chk("stall_hold_b", {o_vld, o_ch, o_cnt, o_sat}, {1'b1, 2'd2, 4'd15, 1'b1});
    push(2, 6, 0);
    tick(4'h4);
    chk("stall_hold_c", {o_vld, o_ch, o_cnt, o_sat}, {1'b1, 2'd2, 4'd15, 1'b1});
    chk("ovr_set", o_ovr, 4'b0100);
    o_rdy = 1'b1;
    idle(10);
    chk("ovr_sticky", o_ovr, 4'b0100);

    // en drop while ch3's result is on the output; also clears ovr[2]
    o_rdy = 1'b0;
    tick(4'h8); idle(3);
    chk("en_drop_pre", {o_vld, o_ch}, {1'b1, 2'd3});
    en = 4'b0011;
    tick(4'h0);
    en = 4'hF;
    chk("en_drop_vld", o_vld, 1'b0);
    chk("en_drop_ovr", o_ovr, 4'h0);
    o_rdy = 1'b1;
    idle(3);
    tick(4'h8); idle(6);
    push(3, 7, 0);
    tick(4'h8); idle(10);
    chk("ovr3_clear", o_ovr[3], 1'b0);

    // reset during traffic kills the in-flight result and re-arms the filter
    push(0, 15, 1);
    tick(4'h1); idle(5);
    tick(4'h1);
    rst = 1'b1; tick(4'h0); rst = 1'b0;
    chk_zero("reset_traffic");
    tick(4'h1); idle(8);
    push(0, 9, 0);
    tick(4'h1); idle(10);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
